eth_rx_ring: RTL and testbench
==============================

// Module: eth_rx_ring
// PURPOSE
// Parametrised receive buffer ring for the Ethernet framing path, clk_int domain.
// Takes the MAC rx AXI-stream byte by byte and filters on destination MAC.
// Commits accepted frames into NBUF slots of BUF_BYTES each, tracking head/tail
// indices and per-slot lengths. Drops on full, filter miss, oversize, short or
// errored frames (counted), exposes a DATA_W-wide host read port and raises eth_irq.
// PARAMETERS
// NBUF       8     slot count; power of 2, >=2
// BUF_BYTES  2048  bytes per slot; power of 2, >=64
// DATA_W     64    host read width; power of 2, 8..64
// DROP_W     16    drop counter width
// (derived) BW=$clog2(NBUF), LEN_W=$clog2(BUF_BYTES)+1, AW=$clog2(BUF_BYTES*8/DATA_W)
// PORTS
// clk_int         in   1       125 MHz clock, sole clock
// rst_int_n       in   1       asynchronous active-low reset
// rx_axis_tdata   in   8       received byte
// rx_axis_tvalid  in   1       byte valid; no backpressure, every valid byte is consumed
// rx_axis_tlast   in   1       last byte of frame
// rx_axis_tuser   in   1       frame error (FCS/PHY); sampled with tlast
// mac_address     in   48      station address, [47:40] = first byte on wire
// promiscuous     in   1       accept every destination
// irq_en          in   1       interrupt enable
// host_rd_en      in   1       read strobe
// host_rd_buf     in   BW      slot to read
// host_rd_addr    in   AW      word address inside slot
// host_rd_data    out  DATA_W  registered read data
// rel_pulse       in   1       host releases head slot
// head_idx        out  BW      oldest committed slot
// tail_idx        out  BW      slot being filled next
// count           out  BW+1    committed slots, 0..NBUF
// head_len        out  LEN_W   byte length of head slot; 0 when count==0
// drop_cnt        out  DROP_W  dropped frames, saturating
// eth_irq         out  1       registered interrupt
// BEHAVIOUR
// - Reset: state IDLE; head/tail/count/drop_cnt=0; eth_irq=0; host_rd_data=0. Slot RAM and length regs not reset.
// - Reset mid-frame: frame lost, no commit, no drop count.
// - FSM IDLE: first valid byte. count==NBUF -> DISCARD. Else write byte 0 to slot tail, wptr=1 -> HDR.
// - FSM HDR: write bytes, shift dest MAC in (first byte MSB).
//   On 6th byte (tlast clear): accept iff dest==mac_address | dest==48'hFFFFFFFFFFFF | dest[47:24]==24'h01005E | promiscuous.
//   Accept -> BODY, else -> DISCARD.
// - FSM BODY: write byte at wptr, wptr++. Byte wptr==BUF_BYTES without tlast -> DISCARD (oversize).
// - Commit: tlast in BODY with tuser=0 -> len[tail]=wptr+1, tail++, count++ on the same edge; visible next cycle.
// - Drops: any tlast in HDR (frame <=6 bytes), or tlast with tuser=1 -> drop, IDLE.
// - FSM DISCARD: ignore bytes until tlast, then IDLE. drop_cnt+1 once per dropped frame, saturating at all-ones.
// - Slot byte i sits at word i/(DATA_W/8), lane i%(DATA_W/8), lane 0 = bits [7:0].
// - Release: rel_pulse & count!=0 -> head++, count--. rel_pulse with count==0 is ignored.
// - Commit+release in the same cycle: count unchanged, both indices advance.
// - Indices wrap modulo NBUF. A full ring never overwrites an uncommitted-head slot.
// - Host read: host_rd_en -> host_rd_data valid next cycle (1-cycle latency); holds value while host_rd_en low.
//   Reading the slot at tail_idx returns undefined data.
// - eth_irq <= irq_en & (count!=0), registered; drops one cycle after irq_en or count falls.
// TESTING
// 1. Frame to mac_address, 64 bytes, tuser=0 -> count=1, head_len=64, read word0 = bytes0..7 little-endian, eth_irq=1 if irq_en.
// 2. Broadcast, multicast 01:00:5E:xx, and other-unicast frames with promiscuous=0 -> 2 commits, drop_cnt=1; promiscuous=1 -> all commit.
// 3. Fill NBUF=8 slots, send 9th -> drop_cnt+1, count=8. Release once, resend -> tail wraps to 0, count=8.
// 4. 2049-byte frame -> dropped. 5-byte frame -> dropped. tuser=1 on tlast -> dropped. count unchanged.
// 5. rel_pulse on the cycle a commit occurs with count=3 -> count stays 3, head and tail both +1. rel_pulse at count=0 -> no change.
// 6. rst_int_n low mid-frame -> all outputs at reset values. Next good frame commits to slot 0 with correct length.

Source files
------------

// File: rtl/eth_rx_ring.sv
// Ethernet receive buffer ring: filters MAC rx bytes on destination address,
// commits accepted frames into NBUF slots and exposes them to a host read port.
module eth_rx_ring #(
  parameter  int unsigned NBUF      = 8,
  parameter  int unsigned BUF_BYTES = 2048,
  parameter  int unsigned DATA_W    = 64,
  parameter  int unsigned DROP_W    = 16,
  localparam int unsigned BW        = $clog2(NBUF),
  localparam int unsigned LEN_W     = $clog2(BUF_BYTES) + 1,
  localparam int unsigned AW        = $clog2(BUF_BYTES * 8 / DATA_W)
) (
  input  logic              clk_int,
  input  logic              rst_int_n,
  input  logic [7:0]        rx_axis_tdata,
  input  logic              rx_axis_tvalid,
  input  logic              rx_axis_tlast,
  input  logic              rx_axis_tuser,
  input  logic [47:0]       mac_address,
  input  logic              promiscuous,
  input  logic              irq_en,
  input  logic              host_rd_en,
  input  logic [BW-1:0]     host_rd_buf,
  input  logic [AW-1:0]     host_rd_addr,
  output logic [DATA_W-1:0] host_rd_data,
  input  logic              rel_pulse,
  output logic [BW-1:0]     head_idx,
  output logic [BW-1:0]     tail_idx,
  output logic [BW:0]       count,
  output logic [LEN_W-1:0]  head_len,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              eth_irq
);

  localparam int unsigned LANES  = DATA_W / 8;
  localparam int unsigned LSH    = $clog2(LANES);
  localparam int unsigned LANE_W = (LANES > 1) ? LSH : 1;
  localparam int unsigned OFF_W  = LEN_W - 1;
  localparam int unsigned MW     = BW + AW;
  localparam int unsigned DEPTH  = NBUF * (BUF_BYTES / LANES);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_HDR     = 2'd1;
  localparam logic [1:0] S_BODY    = 2'd2;
  localparam logic [1:0] S_DISCARD = 2'd3;

  localparam logic [47:0] BCAST_ADDR = 48'hFFFF_FFFF_FFFF;
  localparam logic [23:0] MCAST_OUI  = 24'h01005E;

  logic [1:0]        state, state_nx;
  logic [LEN_W-1:0]  wptr, wptr_nx;
  logic [39:0]       dest, dest_nx;
  logic [47:0]       dest_c;
  logic              accept_c;
  logic              full_c;
  logic              wr_en_c;
  logic              commit_c;
  logic              drop_c;
  logic              release_c;
  logic [LEN_W-1:0]  commit_len_c;
  logic [OFF_W-1:0]  wr_off_c;
  logic [AW-1:0]     wr_word_c;
  logic [LANE_W-1:0] wr_lane_c;
  logic [MW-1:0]     wr_addr_c;
  logic [BW-1:0]     head_nx, tail_nx;
  logic [BW:0]       count_nx;
  logic [LEN_W-1:0]  head_len_nx;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [LEN_W-1:0]  len_q [NBUF];

  // Frame FSM: header filtering, body capture, drop/commit decisions
  always_comb begin
    state_nx = state;
    wptr_nx  = wptr;
    dest_nx  = dest;
    wr_en_c  = 1'b0;
    commit_c = 1'b0;
    drop_c   = 1'b0;
    full_c   = (count == (BW+1)'(NBUF));
    dest_c   = {dest, rx_axis_tdata};
    accept_c = (dest_c == mac_address) | (dest_c == BCAST_ADDR) |
               (dest_c[47:24] == MCAST_OUI) | promiscuous;
    commit_len_c = wptr + LEN_W'(1);
    if (rx_axis_tvalid) begin
      case (state)
        S_IDLE: begin
          if (rx_axis_tlast) begin
            drop_c = 1'b1;
          end else if (full_c) begin
            drop_c   = 1'b1;
            state_nx = S_DISCARD;
          end else begin
            wr_en_c  = 1'b1;
            wptr_nx  = LEN_W'(1);
            dest_nx  = {32'd0, rx_axis_tdata};
            state_nx = S_HDR;
          end
        end
        S_HDR: begin
          wr_en_c = 1'b1;
          wptr_nx = wptr + LEN_W'(1);
          dest_nx = dest_c[39:0];
          if (rx_axis_tlast) begin
            drop_c   = 1'b1;
            state_nx = S_IDLE;
          end else if (wptr == LEN_W'(5)) begin
            if (accept_c) begin
              state_nx = S_BODY;
            end else begin
              drop_c   = 1'b1;
              state_nx = S_DISCARD;
            end
          end
        end
        S_BODY: begin
          // A byte landing past the slot end makes the frame oversize
          if (wptr == LEN_W'(BUF_BYTES)) begin
            drop_c   = 1'b1;
            state_nx = rx_axis_tlast ? S_IDLE : S_DISCARD;
          end else begin
            wr_en_c = 1'b1;
            wptr_nx = wptr + LEN_W'(1);
            if (rx_axis_tlast) begin
              state_nx = S_IDLE;
              if (rx_axis_tuser) drop_c = 1'b1;
              else               commit_c = 1'b1;
            end
          end
        end
        default: begin
          if (rx_axis_tlast) state_nx = S_IDLE;
        end
      endcase
    end
  end

  // Byte placement: word = offset / lanes, lane = offset % lanes
  always_comb begin
    wr_off_c  = (state == S_IDLE) ? '0 : wptr[OFF_W-1:0];
    wr_word_c = AW'(wr_off_c >> LSH);
    wr_lane_c = (LANES > 1) ? LANE_W'(wr_off_c) : '0;
    wr_addr_c = {tail_idx, wr_word_c};
  end

  // Ring bookkeeping; head_len is precomputed so it tracks the next head
  always_comb begin
    release_c = rel_pulse & (count != '0);
    head_nx   = head_idx + BW'(release_c);
    tail_nx   = tail_idx + BW'(commit_c);
    count_nx  = count + (BW+1)'(commit_c) - (BW+1)'(release_c);
    if (count_nx == '0)
      head_len_nx = '0;
    else if (commit_c && (head_nx == tail_idx))
      head_len_nx = commit_len_c;
    else
      head_len_nx = len_q[head_nx];
  end

  always_ff @(posedge clk_int or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state <= S_IDLE;
      wptr  <= '0;
      dest  <= '0;
    end else begin
      state <= state_nx;
      wptr  <= wptr_nx;
      dest  <= dest_nx;
    end
  end

  always_ff @(posedge clk_int or negedge rst_int_n) begin
    if (!rst_int_n) begin
      head_idx <= '0;
      tail_idx <= '0;
      count    <= '0;
      head_len <= '0;
      drop_cnt <= '0;
      eth_irq  <= 1'b0;
    end else begin
      head_idx <= head_nx;
      tail_idx <= tail_nx;
      count    <= count_nx;
      head_len <= head_len_nx;
      if (drop_c && (drop_cnt != '1)) drop_cnt <= drop_cnt + DROP_W'(1);
      eth_irq  <= irq_en & (count != '0);
    end
  end

  always_ff @(posedge clk_int) begin
    if (commit_c) len_q[tail_idx] <= commit_len_c;
  end

  always_ff @(posedge clk_int) begin
    if (wr_en_c) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        if (wr_lane_c == LANE_W'(l)) mem[wr_addr_c][l*8 +: 8] <= rx_axis_tdata;
      end
    end
  end

  // Host read port, one-cycle latency, holds while idle
  always_ff @(posedge clk_int or negedge rst_int_n) begin
    if (!rst_int_n) begin
      host_rd_data <= '0;
    end else if (host_rd_en) begin
      host_rd_data <= mem[{host_rd_buf, host_rd_addr}];
    end
  end

endmodule

// File: tb/tb_eth_rx_ring.sv
// Directed bench for eth_rx_ring: filtering, ring wrap, drops, release and reset.
module tb_eth_rx_ring;

  localparam int unsigned BW     = 3;
  localparam int unsigned LEN_W  = 12;
  localparam int unsigned AW     = 8;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned DROP_W = 16;

  localparam logic [47:0] MAC   = 48'h02_11_22_33_44_55;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] MCAST = 48'h01_00_5E_12_34_56;
  localparam logic [47:0] OTHER = 48'h02_99_88_77_66_55;

  logic              clk_int = 1'b0;
  logic              rst_int_n;
  logic [7:0]        rx_axis_tdata;
  logic              rx_axis_tvalid;
  logic              rx_axis_tlast;
  logic              rx_axis_tuser;
  logic [47:0]       mac_address;
  logic              promiscuous;
  logic              irq_en;
  logic              host_rd_en;
  logic [BW-1:0]     host_rd_buf;
  logic [AW-1:0]     host_rd_addr;
  logic [DATA_W-1:0] host_rd_data;
  logic              rel_pulse;
  logic [BW-1:0]     head_idx;
  logic [BW-1:0]     tail_idx;
  logic [BW:0]       count;
  logic [LEN_W-1:0]  head_len;
  logic [DROP_W-1:0] drop_cnt;
  logic              eth_irq;

  int vectors = 0;
  int miscompares = 0;

  eth_rx_ring dut (
    .clk_int        (clk_int),
    .rst_int_n      (rst_int_n),
    .rx_axis_tdata  (rx_axis_tdata),
    .rx_axis_tvalid (rx_axis_tvalid),
    .rx_axis_tlast  (rx_axis_tlast),
    .rx_axis_tuser  (rx_axis_tuser),
    .mac_address    (mac_address),
    .promiscuous    (promiscuous),
    .irq_en         (irq_en),
    .host_rd_en     (host_rd_en),
    .host_rd_buf    (host_rd_buf),
    .host_rd_addr   (host_rd_addr),
    .host_rd_data   (host_rd_data),
    .rel_pulse      (rel_pulse),
    .head_idx       (head_idx),
    .tail_idx       (tail_idx),
    .count          (count),
    .head_len       (head_len),
    .drop_cnt       (drop_cnt),
    .eth_irq        (eth_irq)
  );

  always #4 clk_int = ~clk_int;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_int);
    #1;
  endtask

  // Bytes 0..5 carry the destination, byte i>=6 carries (seed + i) mod 256
  task automatic send_frame(input logic [47:0] da, input int n, input logic user,
                            input logic [7:0] seed, input logic rel_last);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      if (i < 6) b = da[47-8*i -: 8];
      else       b = 8'(i + int'(seed));
      rx_axis_tdata  = b;
      rx_axis_tvalid = 1'b1;
      rx_axis_tlast  = (i == n - 1);
      rx_axis_tuser  = user && (i == n - 1);
      rel_pulse      = rel_last && (i == n - 1);
      tick();
    end
    rx_axis_tvalid = 1'b0;
    rx_axis_tlast  = 1'b0;
    rx_axis_tuser  = 1'b0;
    rel_pulse      = 1'b0;
  endtask

  task automatic release_head();
    rel_pulse = 1'b1;
    tick();
    rel_pulse = 1'b0;
  endtask

  task automatic host_read(input logic [BW-1:0] slot, input logic [AW-1:0] addr);
    host_rd_en   = 1'b1;
    host_rd_buf  = slot;
    host_rd_addr = addr;
    tick();
    host_rd_en   = 1'b0;
  endtask

  task automatic check_ring(input string tag, input int c, input int h, input int t,
                            input int len, input int drops);
    check({tag, ".count"},    64'(count),    64'(c));
    check({tag, ".head"},     64'(head_idx), 64'(h));
    check({tag, ".tail"},     64'(tail_idx), 64'(t));
    check({tag, ".head_len"}, 64'(head_len), 64'(len));
    check({tag, ".drops"},    64'(drop_cnt), 64'(drops));
  endtask

  initial begin
    rst_int_n      = 1'b0;
    rx_axis_tdata  = '0;
    rx_axis_tvalid = 1'b0;
    rx_axis_tlast  = 1'b0;
    rx_axis_tuser  = 1'b0;
    mac_address    = MAC;
    promiscuous    = 1'b0;
    irq_en         = 1'b0;
    host_rd_en     = 1'b0;
    host_rd_buf    = '0;
    host_rd_addr   = '0;
    rel_pulse      = 1'b0;
    repeat (3) tick();
    check_ring("reset", 0, 0, 0, 0, 0);
    check("reset.irq", 64'(eth_irq), 64'd0);
    check("reset.rd_data", host_rd_data, 64'd0);
    rst_int_n = 1'b1;
    irq_en    = 1'b1;
    tick();

    // Unicast to station address, 64 bytes -> slot 0
    send_frame(MAC, 64, 1'b0, 8'h00, 1'b0);
    check_ring("t1", 1, 0, 1, 64, 0);
    tick();
    check("t1.irq", 64'(eth_irq), 64'd1);
    host_read(3'd0, 8'd0);
    check("t1.word0", host_rd_data, 64'h0706_5544_3322_1102);
    host_read(3'd0, 8'd7);
    check("t1.word7", host_rd_data, 64'h3F3E_3D3C_3B3A_3938);
    tick();
    check("t1.rd_hold", host_rd_data, 64'h3F3E_3D3C_3B3A_3938);

    // Filter: broadcast and multicast accepted, foreign unicast dropped
    send_frame(BCAST, 70, 1'b0, 8'h00, 1'b0);
    send_frame(MCAST, 60, 1'b0, 8'h00, 1'b0);
    send_frame(OTHER, 60, 1'b0, 8'h00, 1'b0);
    check_ring("t2", 3, 0, 3, 64, 1);
    host_read(3'd2, 8'd0);
    check("t2.mcast_word0", host_rd_data, 64'h0706_5634_125E_0001);
    promiscuous = 1'b1;
    send_frame(OTHER, 60, 1'b0, 8'h00, 1'b0);
    promiscuous = 1'b0;
    check_ring("t2p", 4, 0, 4, 64, 1);

    // Fill the ring, overflow, release one and reuse the freed slot
    send_frame(MAC, 80, 1'b0, 8'h00, 1'b0);
    send_frame(MAC, 90, 1'b0, 8'h00, 1'b0);
    send_frame(MAC, 100, 1'b0, 8'h00, 1'b0);
    send_frame(MAC, 110, 1'b0, 8'h00, 1'b0);
    check_ring("t3full", 8, 0, 0, 64, 1);
    send_frame(MAC, 64, 1'b0, 8'h00, 1'b0);
    check_ring("t3ovf", 8, 0, 0, 64, 2);
    release_head();
    check_ring("t3rel", 7, 1, 0, 70, 2);
    send_frame(MAC, 64, 1'b0, 8'h40, 1'b0);
    check_ring("t3wrap", 8, 1, 1, 70, 2);
    host_read(3'd0, 8'd0);
    check("t3.word0", host_rd_data, 64'h4746_5544_3322_1102);

    // Commit and release on the same edge
    repeat (5) release_head();
    check_ring("t5pre", 3, 6, 1, 100, 2);
    send_frame(MAC, 120, 1'b0, 8'h00, 1'b1);
    check_ring("t5both", 3, 7, 2, 110, 2);
    release_head();
    check_ring("t5r1", 2, 0, 2, 64, 2);
    release_head();
    check_ring("t5r2", 1, 1, 2, 120, 2);
    release_head();
    check_ring("t5r3", 0, 2, 2, 0, 2);
    tick();
    check("t5.irq_empty", 64'(eth_irq), 64'd0);
    release_head();
    check_ring("t5empty_rel", 0, 2, 2, 0, 2);

    // Oversize, runt and errored frames; then an exactly full slot
    send_frame(MAC, 2049, 1'b0, 8'h00, 1'b0);
    check_ring("t4over", 0, 2, 2, 0, 3);
    send_frame(MAC, 5, 1'b0, 8'h00, 1'b0);
    check_ring("t4runt", 0, 2, 2, 0, 4);
    send_frame(MAC, 64, 1'b1, 8'h00, 1'b0);
    check_ring("t4err", 0, 2, 2, 0, 5);
    send_frame(MAC, 2048, 1'b0, 8'h00, 1'b0);
    check_ring("t4max", 1, 2, 3, 2048, 5);
    host_read(3'd2, 8'd255);
    check("t4.last_word", host_rd_data, 64'hFFFE_FDFC_FBFA_F9F8);
    tick();
    check("t4.irq", 64'(eth_irq), 64'd1);
    irq_en = 1'b0;
    tick();
    check("t4.irq_off", 64'(eth_irq), 64'd0);

    // Reset in the middle of a frame
    for (int i = 0; i < 20; i++) begin
      rx_axis_tdata  = (i < 6) ? 8'hFF : 8'(i);
      rx_axis_tvalid = 1'b1;
      tick();
    end
    rx_axis_tvalid = 1'b0;
    rst_int_n = 1'b0;
    #1;
    check_ring("t6rst", 0, 0, 0, 0, 0);
    check("t6.irq", 64'(eth_irq), 64'd0);
    check("t6.rd_data", host_rd_data, 64'd0);
    tick();
    rst_int_n = 1'b1;
    irq_en    = 1'b1;
    tick();
    send_frame(BCAST, 64, 1'b0, 8'h05, 1'b0);
    check_ring("t6after", 1, 0, 1, 64, 0);
    host_read(3'd0, 8'd0);
    check("t6.word0", host_rd_data, 64'h0C0B_FFFF_FFFF_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
